// File: rtl/hex_scan_display.sv
`default_nettype none
// ============================================================================
// hex_scan_display : 4-digit multiplexed 7-segment hex driver (common anode)
// Revision 1.0 - initial release
// ============================================================================
module hex_scan_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    input  logic        blank,
    output logic        a3,
    output logic        a2,
    output logic        a1,
    output logic        a0,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        dp
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]       C_AN_OFF   = 4'b1111;
    localparam logic [6:0]       C_SEG_OFF  = 7'b1111111;

    // Scan state and shadow registers
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       sdp_q, sdp_d;
    logic             tick;

    // Registered pin drivers
    logic [3:0] anode_q, anode_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    logic [3:0] nibble;
    logic [6:0] hex_seg;
    logic [3:0] lz_mask;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            shadow_q <= 16'h0000;
            sdp_q    <= 4'b0000;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        tick     = (cnt_q == C_CNT_LAST);
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        sel_d    = tick ? sel_q + 2'd1 : sel_q;
        shadow_d = ld ? data  : shadow_q;
        sdp_d    = ld ? dp_in : sdp_q;
    end

    // ------------------------------------------------------------------
    // Output decode from the current (pre-update) scan state
    // ------------------------------------------------------------------
    always_comb begin
        nibble = 4'h0;
        case (sel_q)
            2'd0:    nibble = shadow_q[3:0];
            2'd1:    nibble = shadow_q[7:4];
            2'd2:    nibble = shadow_q[11:8];
            default: nibble = shadow_q[15:12];
        endcase
    end

    // Active-low patterns, bit order g..a
    always_comb begin
        hex_seg = C_SEG_OFF;
        case (nibble)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    end

    always_comb begin
        // A digit is a leading zero only if every more-significant nibble is zero too
        lz_mask[3] = (shadow_q[15:12] == 4'h0);
        lz_mask[2] = (shadow_q[15:8]  == 8'h00);
        lz_mask[1] = (shadow_q[15:4]  == 12'h000);
        lz_mask[0] = 1'b0;

        anode_d = C_AN_OFF;
        seg_d   = C_SEG_OFF;
        dp_d    = 1'b1;
        if (!blank && !(lz_en && lz_mask[sel_q])) begin
            anode_d        = C_AN_OFF;
            anode_d[sel_q] = 1'b0;
            seg_d          = hex_seg;
            dp_d           = ~sdp_q[sel_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anode_q <= C_AN_OFF;
            seg_q   <= C_SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign {a3, a2, a1, a0}         = anode_q;
    assign {g, f, e, d, c, b, a}    = seg_q;
    assign dp                       = dp_q;

endmodule
`default_nettype wire
